mux2_rr_arbiter: RTL and testbench

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

---
 rtl/mux2_arb_pkg.sv | 12 +
 rtl/arb_mux2w.sv | 13 +
 rtl/mux2_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types for the two-input round-robin packet arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/arb_mux2w.sv
// Combinational 2:1 select of the packed {data, last} beat feeding the output register.
module arb_mux2w #(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-input packet arbiter with round-robin tie-break, burst cap and a registered output stage.
// Optional per-input grant counters are enabled with the ARB_STATS_EN macro.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in0_valid,
  input  logic [WIDTH-1:0]   in0_data,
  input  logic               in0_last,
  output logic               in0_ready,
  input  logic               in1_valid,
  input  logic [WIDTH-1:0]   in1_data,
  input  logic               in1_last,
  output logic               in1_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               sel
`ifdef ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_cnt0,
  output logic [STATS_W-1:0] pkt_cnt1
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic             prio_q, prio_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic             can_accept;
  logic             accept;
  logic             release_lock;
  logic             grant;
  logic             grant_idx;
  logic [WIDTH:0]   beat_sel;

  // sel_q equals the locked index in both LOCK states, so it steers the beat mux directly.
  arb_mux2w #(.W(WIDTH + 1)) u_beat_mux (
    .sel (sel_q),
    .in0 ({in0_data, in0_last}),
    .in1 ({in1_data, in1_last}),
    .out (beat_sel)
  );

  assign can_accept   = !out_valid_q || out_ready;
  assign accept       = can_accept && (((state_q == LOCK0) && in0_valid) ||
                                       ((state_q == LOCK1) && in1_valid));
  assign release_lock = accept && (beat_sel[0] || (beat_cnt_q == BURST_LAST));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      state_q <= state_d;
    end
  end

  // Next-state logic; a tie is won by the input not released last.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) state_d = prio_q ? LOCK0 : LOCK1;
        else if (in0_valid)         state_d = LOCK0;
        else if (in1_valid)         state_d = LOCK1;
      end
      LOCK0, LOCK1: begin
        if (release_lock) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in0_ready = (state_q == LOCK0) && can_accept;
    in1_ready = (state_q == LOCK1) && can_accept;
  end

  assign grant     = (state_q == IDLE) && (state_d != IDLE);
  assign grant_idx = (state_d == LOCK1);

  always_comb begin
    // NOTE: every comb output takes a default first so no path infers a latch.
    prio_d      = prio_q;
    sel_d       = sel_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (grant) sel_d = grant_idx;

    if (release_lock) begin
      prio_d     = sel_q;
      beat_cnt_d = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end

    // The payload only moves on accept, so it holds while stalled.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_sel[WIDTH:1];
      out_last_d  = beat_sel[0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b1;
      sel_q       <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      // NOTE: the payload register is reset too, so out_data reads zero before the first beat.
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      sel_q       <= sel_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

`ifdef ARB_STATS_EN
  logic [STATS_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [STATS_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  // Grant counters saturate instead of wrapping.
  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (grant && !grant_idx && (pkt_cnt0_q != '1)) pkt_cnt0_d = pkt_cnt0_q + STATS_W'(1);
    if (grant &&  grant_idx && (pkt_cnt1_q != '1)) pkt_cnt1_d = pkt_cnt1_q + STATS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter (WIDTH=8, MAX_BURST=4).
module tb_mux2_rr_arbiter;
  import mux2_arb_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in0_valid, in0_last, in0_ready;
  logic             in1_valid, in1_last, in1_ready;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             out_valid, out_last, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             sel;
`ifdef ARB_STATS_EN
  logic [STATS_W-1:0] pkt_cnt0, pkt_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel)
`ifdef ARB_STATS_EN
    ,
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic l);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".last"},  32'(out_last),  32'(l));
  endtask

  task automatic check_ctl(input string tag, input arb_state_e st, input logic s,
                           input logic r0, input logic r1);
    check({tag, ".state"}, 32'(dut.state_q), 32'(st));
    check({tag, ".sel"},   32'(sel),         32'(s));
    check({tag, ".rdy0"},  32'(in0_ready),   32'(r0));
    check({tag, ".rdy1"},  32'(in1_ready),   32'(r1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single-beat packet on one input served alone: grant, accept, drain.
  task automatic send_single(input logic idx, input logic [7:0] d);
    if (idx) begin in1_valid = 1'b1; in1_data = d; in1_last = 1'b1; end
    else     begin in0_valid = 1'b1; in0_data = d; in0_last = 1'b1; end
    step();
    step();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    step();
  endtask

  initial begin
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b1;
    do_reset();

    // Reset state
    check_out("rst", 1'b0, 8'h00, 1'b0);
    check_ctl("rst", IDLE, 1'b0, 1'b0, 1'b0);
    check("rst.prio", 32'(dut.prio_q), 32'd1);
    check("rst.cnt",  32'(dut.beat_cnt_q), 32'd0);
    step();
    check_ctl("idle_hold", IDLE, 1'b0, 1'b0, 1'b0);

    // Single source, three-beat packet
    in0_valid = 1'b1; in0_data = 8'hA1; in0_last = 1'b0;
    step();
    check_ctl("s1.grant", LOCK0, 1'b0, 1'b1, 1'b0);
    check("s1.grant.ov", 32'(out_valid), 32'd0);
    step();
    check_out("s1.b1", 1'b1, 8'hA1, 1'b0);
    in0_data = 8'hA2;
    step();
    check_out("s1.b2", 1'b1, 8'hA2, 1'b0);
    in0_data = 8'hA3; in0_last = 1'b1;
    step();
    check_out("s1.b3", 1'b1, 8'hA3, 1'b1);
    check_ctl("s1.rel", IDLE, 1'b0, 1'b0, 1'b0);
    check("s1.prio", 32'(dut.prio_q), 32'd0);
    in0_valid = 1'b0; in0_last = 1'b0;
    step();
    check("s1.drain", 32'(out_valid), 32'd0);

    // Tie after reset: input 0 first, bubble, then input 1
    do_reset();
    in0_valid = 1'b1; in0_data = 8'h11; in0_last = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h22; in1_last = 1'b1;
    step();
    check_ctl("tie.g0", LOCK0, 1'b0, 1'b1, 1'b0);
    step();
    check_out("tie.o0", 1'b1, 8'h11, 1'b1);
    check_ctl("tie.bubble", IDLE, 1'b0, 1'b0, 1'b0);
    in0_valid = 1'b0;
    step();
    check_ctl("tie.g1", LOCK1, 1'b1, 1'b0, 1'b1);
    check("tie.gap", 32'(out_valid), 32'd0);
    step();
    check_out("tie.o1", 1'b1, 8'h22, 1'b1);
    check("tie.prio", 32'(dut.prio_q), 32'd1);
    in1_valid = 1'b0;
    step();

    // Burst cap: in1 six beats, in0 waiting
    in1_valid = 1'b1; in1_last = 1'b0;
    step();
    check_ctl("cap.g1", LOCK1, 1'b1, 1'b0, 1'b1);
    in0_valid = 1'b1; in0_data = 8'h50; in0_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in1_data = 8'hB0 + 8'(k);
      step();
      check_out($sformatf("cap.b%0d", k), 1'b1, 8'hB0 + 8'(k), 1'b0);
    end
    check_ctl("cap.rel", IDLE, 1'b1, 1'b0, 1'b0);
    check("cap.cnt", 32'(dut.beat_cnt_q), 32'd0);
    step();
    check_ctl("cap.g0", LOCK0, 1'b0, 1'b1, 1'b0);
    step();
    check_out("cap.o0", 1'b1, 8'h50, 1'b1);
    in0_valid = 1'b0;
    step();
    check_ctl("cap.regrant", LOCK1, 1'b1, 1'b0, 1'b1);
    in1_data = 8'hB4;
    step();
    check_out("cap.b4", 1'b1, 8'hB4, 1'b0);
    in1_data = 8'hB5; in1_last = 1'b1;
    step();
    check_out("cap.b5", 1'b1, 8'hB5, 1'b1);
    check("cap.end", 32'(dut.state_q), 32'(IDLE));
    in1_valid = 1'b0; in1_last = 1'b0;
    step();

    // Backpressure mid-packet
    in0_valid = 1'b1; in0_data = 8'hC1; in0_last = 1'b0;
    step();
    step();
    check_out("bp.c1", 1'b1, 8'hC1, 1'b0);
    in0_data  = 8'hC2;
    out_ready = 1'b0;
    #1;
    check("bp.rdy_low", 32'(in0_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("bp.hold%0d", k), 1'b1, 8'hC1, 1'b0);
      check($sformatf("bp.rdy%0d", k), 32'(in0_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.rdy_back", 32'(in0_ready), 32'd1);
    step();
    check_out("bp.c2", 1'b1, 8'hC2, 1'b0);
    in0_data = 8'hC3; in0_last = 1'b1;
    step();
    check_out("bp.c3", 1'b1, 8'hC3, 1'b1);
    in0_valid = 1'b0; in0_last = 1'b0;
    step();
    check("bp.drain", 32'(out_valid), 32'd0);

    // Reset after the second beat of an in1 packet
    in1_valid = 1'b1; in1_data = 8'hD1; in1_last = 1'b0;
    step();
    check_ctl("rm.g1", LOCK1, 1'b1, 1'b0, 1'b1);
    step();
    in1_data = 8'hD2;
    step();
    check_out("rm.d2", 1'b1, 8'hD2, 1'b0);
    in1_data = 8'hD3;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rm.async", 1'b0, 8'h00, 1'b0);
    check_ctl("rm.async", IDLE, 1'b0, 1'b0, 1'b0);
    check("rm.prio", 32'(dut.prio_q), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("rm.regrant", 32'(dut.state_q), 32'(LOCK1));
    check("rm.no_beat", 32'(out_valid), 32'd0);
    in1_last = 1'b1;
    step();
    check_out("rm.d3", 1'b1, 8'hD3, 1'b1);
    in1_valid = 1'b0; in1_last = 1'b0;
    step();

`ifdef ARB_STATS_EN
    do_reset();
    check("st.rst0", 32'(pkt_cnt0), 32'd0);
    check("st.rst1", 32'(pkt_cnt1), 32'd0);
    send_single(1'b0, 8'h01);
    send_single(1'b1, 8'h02);
    send_single(1'b0, 8'h03);
    send_single(1'b1, 8'h04);
    send_single(1'b0, 8'h05);
    check("st.cnt0", 32'(pkt_cnt0), 32'd3);
    check("st.cnt1", 32'(pkt_cnt1), 32'd2);
    force dut.pkt_cnt0_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt0_q;
    send_single(1'b0, 8'h06);
    check("st.near", 32'(pkt_cnt0), 32'hFFFF);
    send_single(1'b0, 8'h07);
    check("st.sat", 32'(pkt_cnt0), 32'hFFFF);
    check("st.cnt1_keep", 32'(pkt_cnt1), 32'd2);
`else
    send_single(1'b0, 8'h01);
    check_out("tail", 1'b0, 8'h01, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
